// File: rtl/reg_mux_rr.sv
// Registered N:1 channel mux with a fixed-select mode and an optional round-robin mode.
// Round-robin support is compiled in only when MUX_RR_EN is defined; otherwise mode is ignored.
module reg_mux_rr #(
    parameter  int WIDTH = 8,
    parameter  int CH    = 4,
    localparam int SELW  = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*WIDTH-1:0]   in_data,
    input  logic [CH-1:0]         in_valid,
    output logic [CH-1:0]         in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic                  mode,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       cur_ch
);

    localparam int unsigned CHU = CH;

    logic             load_en;
    logic             load;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt;
    logic [WIDTH-1:0] gnt_data;
    logic             fix_vld;

    assign load_en = !out_valid || out_ready;
    assign load    = gnt_vld && load_en && !rst;

    // sel may exceed CH-1 when CH is not a power of two; such a select grants nothing.
    always_comb begin
        fix_vld = 1'b0;
        if (32'(sel) < CHU) begin
            fix_vld = in_valid[sel];
        end
    end

`ifdef MUX_RR_EN
    logic [SELW-1:0] ptr;
    logic            rr_vld;
    logic [SELW-1:0] rr_gnt;
    int unsigned     idx;
    logic [SELW-1:0] idx_s;

    // First valid channel at or after ptr, wrapping modulo CH.
    always_comb begin
        rr_vld = 1'b0;
        rr_gnt = '0;
        idx    = 0;
        idx_s  = '0;
        for (int unsigned i = 0; i < CHU; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= CHU) begin
                idx = idx - CHU;
            end
            idx_s = idx[SELW-1:0];
            if (!rr_vld && in_valid[idx_s]) begin
                rr_vld = 1'b1;
                rr_gnt = idx_s;
            end
        end
    end

    always_comb begin
        if (mode) begin
            gnt_vld = rr_vld;
            gnt     = rr_gnt;
        end else begin
            gnt_vld = fix_vld;
            gnt     = sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load && mode) begin
            ptr <= (gnt == SELW'(CH - 1)) ? '0 : gnt + 1'b1;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        gnt_vld = fix_vld;
        gnt     = sel;
    end
`endif

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int unsigned i = 0; i < CHU; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            cur_ch    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            cur_ch    <= gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_mux_rr.sv
// Directed bench for reg_mux_rr: expected words go into a scoreboard queue when driven
// and are popped when the output register is sampled. Expectations track MUX_RR_EN.
module tb_reg_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  cur_ch;

    logic [23:0] d1;
    logic [2:0]  v1;
    logic [2:0]  r1;
    logic [1:0]  s1;
    logic        m1;
    logic [7:0]  od1;
    logic        ov1;
    logic        or1;
    logic [1:0]  cc1;

    int checks   = 0;
    int failures = 0;
    logic [9:0] sb[$];

    reg_mux_rr #(.WIDTH(8), .CH(4)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .cur_ch(cur_ch)
    );

    reg_mux_rr #(.WIDTH(8), .CH(3)) u1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1),
        .sel(s1), .mode(m1), .out_data(od1), .out_valid(ov1),
        .out_ready(or1), .cur_ch(cc1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are already driven; check ready, clock once, then check the output register.
    task automatic xfer(input string tag, input logic [3:0] er, input bit ld,
                        input logic [7:0] ed, input logic [1:0] ec);
        logic [9:0] e;
        #1;
        chk({tag, ".rdy"}, 32'(in_ready), 32'(er));
        if (ld) sb.push_back({ec, ed});
        @(posedge clk);
        #1;
        chk({tag, ".vld"}, 32'(out_valid), 32'(ld));
        if (ld) begin
            e = sb.pop_front();
            chk({tag, ".data"}, 32'(out_data), 32'(e[7:0]));
            chk({tag, ".ch"}, 32'(cur_ch), 32'(e[9:8]));
        end
    endtask

    task automatic rr_step(input string tag, input logic [1:0] rr_ch, input logic [1:0] fx_ch);
        logic [1:0] c;
        logic [3:0] oh;
`ifdef MUX_RR_EN
        c = rr_ch;
`else
        c = fx_ch;
`endif
        oh = 4'b0001 << c;
        xfer(tag, oh, 1'b1, 8'h10 + 8'(c), c);
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b1111;
        in_data   = '0;
        out_ready = 1'b1;
        d1 = 24'hC2C1C0; v1 = 3'b111; s1 = 2'd0; m1 = 1'b0; or1 = 1'b1;

        #3;
        chk("rst.vld", 32'(out_valid), 0);
        chk("rst.data", 32'(out_data), 0);
        chk("rst.ch", 32'(cur_ch), 0);
        chk("rst.rdy", 32'(in_ready), 0);
        chk("rst.rdy1", 32'(r1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        v1  = 3'b000;

        // Fixed select, first edge after reset release
        in_data = 32'h00A5_0000; in_valid = 4'b0100; sel = 2'd2;
        xfer("fix", 4'b0100, 1'b1, 8'hA5, 2'd0 + 2'd2);

        // Backpressure: hold 3C for three cycles
        in_data = 32'h4433_223C; in_valid = 4'b0001; sel = 2'd0;
        xfer("bp_load", 4'b0001, 1'b1, 8'h3C, 2'd0);
        out_ready = 1'b0; in_valid = 4'b1111; sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            mode = (i == 1);
            #1;
            chk("bp.rdy", 32'(in_ready), 0);
            @(posedge clk);
            #1;
            chk("bp.vld", 32'(out_valid), 1);
            chk("bp.data", 32'(out_data), 32'h3C);
            chk("bp.ch", 32'(cur_ch), 0);
        end
        mode = 1'b0;
        out_ready = 1'b1;
        xfer("bp_rel", 4'b0010, 1'b1, 8'h22, 2'd1);

        in_valid = 4'b0000;
        xfer("drain", 4'b0000, 1'b0, 8'h00, 2'd0);

        // Asynchronous reset between edges with a word held
        in_data = 32'h0000_005A; in_valid = 4'b0001; sel = 2'd0;
        xfer("pre_rst", 4'b0001, 1'b1, 8'h5A, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.vld", 32'(out_valid), 0);
        chk("arst.data", 32'(out_data), 0);
        chk("arst.ch", 32'(cur_ch), 0);
        chk("arst.rdy", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin sweep from ptr=0, then continue to ptr=3
        mode = 1'b1; sel = 2'd2; in_valid = 4'b1111; in_data = 32'h1312_1110;
        rr_step("rr0", 2'd0, 2'd2);
        rr_step("rr1", 2'd1, 2'd2);
        rr_step("rr2", 2'd2, 2'd2);
        rr_step("rr3", 2'd3, 2'd2);
        rr_step("rr4", 2'd0, 2'd2);
        rr_step("rr5", 2'd1, 2'd2);
        rr_step("rr6", 2'd2, 2'd2);

        // Skip and wrap from ptr=3 to channel 1
        in_valid = 4'b0010;
`ifdef MUX_RR_EN
        xfer("rr_wrap", 4'b0010, 1'b1, 8'h11, 2'd1);
`else
        xfer("rr_wrap", 4'b0000, 1'b0, 8'h00, 2'd0);
`endif
        in_valid = 4'b1111;
        rr_step("rr_ptr", 2'd2, 2'd2);

        // Fixed mode must leave ptr (now 3) alone
        mode = 1'b0; sel = 2'd0;
        xfer("fix_hold", 4'b0001, 1'b1, 8'h10, 2'd0);
        mode = 1'b1;
        rr_step("rr_held", 2'd3, 2'd0);

        // Out-of-range select on a 3-channel instance
        s1 = 2'd3; v1 = 3'b111;
        #1;
        chk("bad_sel.rdy", 32'(r1), 0);
        @(posedge clk);
        #1;
        chk("bad_sel.vld", 32'(ov1), 0);
        s1 = 2'd1;
        #1;
        chk("ch3.rdy", 32'(r1), 32'b010);
        @(posedge clk);
        #1;
        chk("ch3.vld", 32'(ov1), 1);
        chk("ch3.data", 32'(od1), 32'hC1);
        chk("ch3.ch", 32'(cc1), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_mux_rr.md
REG_MUX_RR -- requirements
Module: reg_mux_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width per channel (1..64).
REQ-002 SHALL have parameter CH, default 4, input channel count (2..16).
REQ-003 SHALL derive localparam SELW = clog2(CH), select/channel-index width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  CH  per-channel valid.
REQ-008 in_ready  output  CH  per-channel ready; at most one bit high per cycle.
REQ-009 sel  input  SELW  channel select in fixed mode.
REQ-010 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-014 cur_ch  output  SELW  channel index of the word in out_data.

Function
REQ-015 load_en SHALL be (!out_valid || out_ready); the output register loads only when load_en and a grant exists.
REQ-016 Fixed mode: grant SHALL be channel sel when in_valid[sel]=1; sel >= CH SHALL grant nothing, all in_ready low.
REQ-017 Round-robin mode: grant SHALL be the first channel with in_valid set, searching ptr, ptr+1, ... modulo CH.
REQ-018 After a round-robin transfer from channel g, ptr SHALL become g+1, wrapping CH-1 -> 0.
REQ-019 ptr SHALL hold its value in fixed mode and when no transfer occurs.
REQ-020 in_ready[g] SHALL be high only for the granted channel and only when load_en; in_ready is combinational from in_valid, sel, mode, ptr, out_valid, out_ready.
REQ-021 Transfer on channel g SHALL occur in a cycle with in_valid[g] && in_ready[g]; out_data/cur_ch SHALL show the word the following cycle (latency 1).
REQ-022 out_valid SHALL set on a load, clear when out_ready && out_valid with no simultaneous load, and stay high on simultaneous consume and load (full throughput, one word per cycle).
REQ-023 With out_valid=1 and out_ready=0, out_data, cur_ch, out_valid SHALL hold and all in_ready SHALL be low.
REQ-024 A mode or sel change SHALL affect only grants in the same cycle; a held output word is never altered.
REQ-025 No grant (all in_valid low) SHALL leave ptr and the output register unchanged except out_valid clearing per REQ-022.

Reset
REQ-026 rst high SHALL immediately force out_valid=0, out_data=0, cur_ch=0, ptr=0, regardless of clk.
REQ-027 in_ready SHALL be 0 while rst is high; a word pending at reset SHALL be discarded.
REQ-028 First transfer SHALL be possible in the first clock edge after rst deasserts.

Configuration
REQ-029 Macro MUX_RR_EN SHALL control round-robin support.
REQ-030 With MUX_RR_EN defined: behaviour as REQ-017..REQ-019 when mode=1.
REQ-031 Without MUX_RR_EN: ptr and search logic SHALL be absent, mode SHALL be ignored, block SHALL behave as fixed mode always.

Verification
REQ-032 Fixed: WIDTH=8, CH=4, mode=0, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100, next cycle out_data=8'hA5, cur_ch=2, out_valid=1.
REQ-033 Round-robin: mode=1, in_valid=4'b1111 held, out_ready=1, ptr=0 after reset -> cur_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 Round-robin skip/wrap: mode=1, ptr=3, in_valid=4'b0010 -> grant ch1, ptr becomes 2.
REQ-035 Backpressure: out_valid=1 with 8'h3C, out_ready=0 for 3 cycles while in_valid=4'b1111 -> in_ready=0, out_data stays 8'h3C; out_ready=1 -> next word loads same cycle, out_valid stays 1.
REQ-036 Invalid select: CH=3, sel=3, mode=0, in_valid=3'b111 -> in_ready=0, out_valid stays 0.
REQ-037 Async reset mid-stream: assert rst between clk edges while out_valid=1 -> out_valid=0, out_data=0, cur_ch=0 before next edge; without MUX_RR_EN, REQ-033 stimulus SHALL yield cur_ch equal to sel every cycle.
